// File: rtl/cci_mpf_shim_tag_arb.sv
// FIU c0 read-request arbiter shared by AFU pass-through traffic and two internal MPF shims
// (VTP walker, PWRITE reader), with tagged response steering and a drain handshake.
module cci_mpf_shim_tag_arb #(
    parameter int unsigned ADDR_WIDTH      = 42,
    parameter int unsigned MDATA_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH      = 512,
    parameter int unsigned RESERVED_IDX    = 15,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,

    input  logic                   afu_req_valid_i,
    input  logic [ADDR_WIDTH-1:0]  afu_req_addr_i,
    input  logic [MDATA_WIDTH-1:0] afu_req_mdata_i,
    output logic                   afu_req_ready_o,

    input  logic                   vtp_req_valid_i,
    input  logic [ADDR_WIDTH-1:0]  vtp_req_addr_i,
    output logic                   vtp_req_ready_o,

    input  logic                   pw_req_valid_i,
    input  logic [ADDR_WIDTH-1:0]  pw_req_addr_i,
    output logic                   pw_req_ready_o,

    output logic                   fiu_req_valid_o,
    output logic [ADDR_WIDTH-1:0]  fiu_req_addr_o,
    output logic [MDATA_WIDTH-1:0] fiu_req_mdata_o,
    input  logic                   fiu_almost_full_i,

    input  logic                   fiu_rsp_valid_i,
    input  logic [MDATA_WIDTH-1:0] fiu_rsp_mdata_i,
    input  logic [DATA_WIDTH-1:0]  fiu_rsp_data_i,

    output logic [MDATA_WIDTH-1:0] rsp_mdata_o,
    output logic [DATA_WIDTH-1:0]  rsp_data_o,
    output logic                   afu_rsp_valid_o,
    output logic                   vtp_rsp_valid_o,
    output logic                   pw_rsp_valid_o,

    input  logic                   drain_req_i,
    output logic                   drain_done_o,
    output logic                   err_tag_collision_o,
    output logic                   err_orphan_rsp_o
);

    localparam int unsigned     CntW   = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_OUTSTANDING);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    localparam logic [1:0] SrcAfu = 2'd0;
    localparam logic [1:0] SrcVtp = 2'd1;
    localparam logic [1:0] SrcPw  = 2'd2;

    typedef enum logic [1:0] {StRun, StDrain, StDrained} state_e;

    state_e                 state_q, state_d;
    logic [1:0]             rr_q, rr_d;
    logic [CntW-1:0]        vtp_cnt_q, vtp_cnt_d, pw_cnt_q, pw_cnt_d;
    logic [2:0]             elig, grant;

    logic                   req_valid_q, req_valid_d;
    logic [ADDR_WIDTH-1:0]  req_addr_q, req_addr_d;
    logic [MDATA_WIDTH-1:0] req_mdata_q, req_mdata_d;

    logic                   afu_rsp_q, afu_rsp_d, vtp_rsp_q, vtp_rsp_d, pw_rsp_q, pw_rsp_d;
    logic [MDATA_WIDTH-1:0] rsp_mdata_q, rsp_mdata_d;
    logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic                   err_tag_q, err_tag_d, err_orphan_q, err_orphan_d;

    logic                   rsp_tagged, vtp_hit, pw_hit, vtp_dec, pw_dec, orphan;

    always_comb begin
        elig[0] = afu_req_valid_i;
        elig[1] = vtp_req_valid_i && (state_q == StRun) && (vtp_cnt_q < CntMax);
        elig[2] = pw_req_valid_i && (state_q == StRun) && (pw_cnt_q < CntMax);
    end

    // Rotating priority starting at rr_q; readies are forced low while reset is asserted.
    always_comb begin
        grant = 3'b000;
        if (reset_ni && !fiu_almost_full_i) begin
            case (rr_q)
                SrcVtp: begin
                    if (elig[1])      grant = 3'b010;
                    else if (elig[2]) grant = 3'b100;
                    else if (elig[0]) grant = 3'b001;
                end
                SrcPw: begin
                    if (elig[2])      grant = 3'b100;
                    else if (elig[0]) grant = 3'b001;
                    else if (elig[1]) grant = 3'b010;
                end
                default: begin
                    if (elig[0])      grant = 3'b001;
                    else if (elig[1]) grant = 3'b010;
                    else if (elig[2]) grant = 3'b100;
                end
            endcase
        end
    end

    always_comb begin
        rr_d        = rr_q;
        req_valid_d = |grant;
        req_addr_d  = req_addr_q;
        req_mdata_d = req_mdata_q;
        if (grant[0]) begin
            rr_d                      = SrcVtp;
            req_addr_d                = afu_req_addr_i;
            req_mdata_d               = afu_req_mdata_i;
            req_mdata_d[RESERVED_IDX] = 1'b0;
        end else if (grant[1]) begin
            rr_d                      = SrcPw;
            req_addr_d                = vtp_req_addr_i;
            req_mdata_d               = '0;
            req_mdata_d[RESERVED_IDX] = 1'b1;
        end else if (grant[2]) begin
            rr_d                      = SrcAfu;
            req_addr_d                = pw_req_addr_i;
            req_mdata_d               = '0;
            req_mdata_d[RESERVED_IDX] = 1'b1;
            req_mdata_d[0]            = 1'b1;
        end
    end

    always_comb begin
        rsp_tagged = fiu_rsp_mdata_i[RESERVED_IDX];
        vtp_hit    = fiu_rsp_valid_i && rsp_tagged && !fiu_rsp_mdata_i[0];
        pw_hit     = fiu_rsp_valid_i && rsp_tagged && fiu_rsp_mdata_i[0];
        vtp_dec    = vtp_hit && (vtp_cnt_q != '0);
        pw_dec     = pw_hit && (pw_cnt_q != '0);
        orphan     = (vtp_hit && (vtp_cnt_q == '0)) || (pw_hit && (pw_cnt_q == '0));

        afu_rsp_d   = fiu_rsp_valid_i && !rsp_tagged;
        vtp_rsp_d   = vtp_dec;
        pw_rsp_d    = pw_dec;
        rsp_mdata_d = fiu_rsp_valid_i ? fiu_rsp_mdata_i : rsp_mdata_q;
        rsp_data_d  = fiu_rsp_valid_i ? fiu_rsp_data_i : rsp_data_q;

        err_tag_d    = err_tag_q || (grant[0] && afu_req_mdata_i[RESERVED_IDX]);
        err_orphan_d = err_orphan_q || orphan;
    end

    always_comb begin
        vtp_cnt_d = vtp_cnt_q;
        if (grant[1] && !vtp_dec)      vtp_cnt_d = vtp_cnt_q + CntOne;
        else if (!grant[1] && vtp_dec) vtp_cnt_d = vtp_cnt_q - CntOne;

        pw_cnt_d = pw_cnt_q;
        if (grant[2] && !pw_dec)       pw_cnt_d = pw_cnt_q + CntOne;
        else if (!grant[2] && pw_dec)  pw_cnt_d = pw_cnt_q - CntOne;
    end

    // Drain completion looks at next-cycle counts so drain_done follows the last response by one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (drain_req_i) state_d = StDrain;
            end
            StDrain: begin
                if ((vtp_cnt_d == '0) && (pw_cnt_d == '0)) state_d = StDrained;
                else if (!drain_req_i)                      state_d = StRun;
            end
            StDrained: begin
                if (!drain_req_i) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= StRun;
            rr_q         <= SrcAfu;
            vtp_cnt_q    <= '0;
            pw_cnt_q     <= '0;
            req_valid_q  <= 1'b0;
            req_addr_q   <= '0;
            req_mdata_q  <= '0;
            afu_rsp_q    <= 1'b0;
            vtp_rsp_q    <= 1'b0;
            pw_rsp_q     <= 1'b0;
            rsp_mdata_q  <= '0;
            rsp_data_q   <= '0;
            err_tag_q    <= 1'b0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            vtp_cnt_q    <= vtp_cnt_d;
            pw_cnt_q     <= pw_cnt_d;
            req_valid_q  <= req_valid_d;
            req_addr_q   <= req_addr_d;
            req_mdata_q  <= req_mdata_d;
            afu_rsp_q    <= afu_rsp_d;
            vtp_rsp_q    <= vtp_rsp_d;
            pw_rsp_q     <= pw_rsp_d;
            rsp_mdata_q  <= rsp_mdata_d;
            rsp_data_q   <= rsp_data_d;
            err_tag_q    <= err_tag_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign afu_req_ready_o     = grant[0];
    assign vtp_req_ready_o     = grant[1];
    assign pw_req_ready_o      = grant[2];
    assign fiu_req_valid_o     = req_valid_q;
    assign fiu_req_addr_o      = req_addr_q;
    assign fiu_req_mdata_o     = req_mdata_q;
    assign rsp_mdata_o         = rsp_mdata_q;
    assign rsp_data_o          = rsp_data_q;
    assign afu_rsp_valid_o     = afu_rsp_q;
    assign vtp_rsp_valid_o     = vtp_rsp_q;
    assign pw_rsp_valid_o      = pw_rsp_q;
    assign drain_done_o        = (state_q == StDrained);
    assign err_tag_collision_o = err_tag_q;
    assign err_orphan_rsp_o    = err_orphan_q;

endmodule

// File: tb/tb_cci_mpf_shim_tag_arb.sv
// Scoreboard bench for cci_mpf_shim_tag_arb: request/response expectations are queued as
// stimulus is driven and checked by monitors as the DUT emits them.
module tb_cci_mpf_shim_tag_arb;

    localparam int unsigned AW = 42;
    localparam int unsigned MW = 16;
    localparam int unsigned DW = 512;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          afu_v = 1'b0, vtp_v = 1'b0, pw_v = 1'b0;
    logic [AW-1:0] afu_a = '0, vtp_a = '0, pw_a = '0;
    logic [MW-1:0] afu_m = '0;
    logic          afu_rdy, vtp_rdy, pw_rdy;
    logic          fiu_v;
    logic [AW-1:0] fiu_a;
    logic [MW-1:0] fiu_m;
    logic          af = 1'b0;
    logic          rsp_v = 1'b0;
    logic [MW-1:0] rsp_m = '0;
    logic [DW-1:0] rsp_d = '0;
    logic [MW-1:0] o_rsp_m;
    logic [DW-1:0] o_rsp_d;
    logic          o_afu_rv, o_vtp_rv, o_pw_rv;
    logic          drain = 1'b0;
    logic          drain_done, err_tag, err_orph;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    logic [AW-1:0] rq_addr[$];
    logic [MW-1:0] rq_mdata[$];
    logic [2:0]    rs_vbits[$];
    logic [MW-1:0] rs_mdata[$];
    logic [DW-1:0] rs_data[$];
    int            cnt_m[3];

    always #5 clk = ~clk;

    cci_mpf_shim_tag_arb dut (
        .clk_i               (clk),
        .reset_ni            (reset_n),
        .afu_req_valid_i     (afu_v),
        .afu_req_addr_i      (afu_a),
        .afu_req_mdata_i     (afu_m),
        .afu_req_ready_o     (afu_rdy),
        .vtp_req_valid_i     (vtp_v),
        .vtp_req_addr_i      (vtp_a),
        .vtp_req_ready_o     (vtp_rdy),
        .pw_req_valid_i      (pw_v),
        .pw_req_addr_i       (pw_a),
        .pw_req_ready_o      (pw_rdy),
        .fiu_req_valid_o     (fiu_v),
        .fiu_req_addr_o      (fiu_a),
        .fiu_req_mdata_o     (fiu_m),
        .fiu_almost_full_i   (af),
        .fiu_rsp_valid_i     (rsp_v),
        .fiu_rsp_mdata_i     (rsp_m),
        .fiu_rsp_data_i      (rsp_d),
        .rsp_mdata_o         (o_rsp_m),
        .rsp_data_o          (o_rsp_d),
        .afu_rsp_valid_o     (o_afu_rv),
        .vtp_rsp_valid_o     (o_vtp_rv),
        .pw_rsp_valid_o      (o_pw_rv),
        .drain_req_i         (drain),
        .drain_done_o        (drain_done),
        .err_tag_collision_o (err_tag),
        .err_orphan_rsp_o    (err_orph)
    );

    // Request monitor: each pushed grant must appear on fiu_req_* exactly one cycle later.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (rq_addr.size() > 0) begin
                logic [AW-1:0] ea;
                logic [MW-1:0] em;
                ea = rq_addr.pop_front();
                em = rq_mdata.pop_front();
                if (fiu_v !== 1'b1 || fiu_a !== ea || fiu_m !== em) begin
                    failures++;
                    $display("FAIL fiu_req: got v=%0b addr=%h mdata=%h, want v=1 addr=%h mdata=%h",
                             fiu_v, fiu_a, fiu_m, ea, em);
                end
            end else if (fiu_v !== 1'b0) begin
                failures++;
                $display("FAIL fiu_req_idle: got v=%b, want 0", fiu_v);
            end
        end
    end

    // Response monitor: steering bits {pw,vtp,afu} and echoed mdata/data one cycle after input.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (rs_vbits.size() > 0) begin
                logic [2:0]    ev;
                logic [MW-1:0] em;
                logic [DW-1:0] ed;
                ev = rs_vbits.pop_front();
                em = rs_mdata.pop_front();
                ed = rs_data.pop_front();
                if ({o_pw_rv, o_vtp_rv, o_afu_rv} !== ev || o_rsp_m !== em || o_rsp_d !== ed) begin
                    failures++;
                    $display("FAIL rsp_steer: got pw/vtp/afu=%b mdata=%h data[31:0]=%h, want %b %h %h",
                             {o_pw_rv, o_vtp_rv, o_afu_rv}, o_rsp_m, o_rsp_d[31:0], ev, em, ed[31:0]);
                end
            end else if ({o_pw_rv, o_vtp_rv, o_afu_rv} !== 3'b000) begin
                failures++;
                $display("FAIL rsp_idle: got pw/vtp/afu=%b, want 000", {o_pw_rv, o_vtp_rv, o_afu_rv});
            end
        end
    end

    task automatic next_cycle();
        @(negedge clk);
        #1;
        rsp_v = 1'b0;
    endtask

    task automatic clear_model();
        rq_addr.delete();
        rq_mdata.delete();
        rs_vbits.delete();
        rs_mdata.delete();
        rs_data.delete();
        for (int i = 0; i < 3; i++) cnt_m[i] = 0;
    endtask

    task automatic idle_inputs();
        afu_v = 1'b0; vtp_v = 1'b0; pw_v = 1'b0; af = 1'b0; rsp_v = 1'b0; drain = 1'b0;
        afu_m = '0;
    endtask

    task automatic do_reset();
        next_cycle();
        mon_en  = 1'b0;
        reset_n = 1'b0;
        idle_inputs();
        clear_model();
        repeat (2) next_cycle();
        reset_n = 1'b1;
        mon_en  = 1'b1;
    endtask

    task automatic push_req(input int src);
        logic [MW-1:0] m;
        m = '0;
        case (src)
            0: begin
                m = afu_m;
                m[15] = 1'b0;
                rq_addr.push_back(afu_a);
            end
            1: begin
                m = 16'h8000;
                rq_addr.push_back(vtp_a);
            end
            default: begin
                m = 16'h8001;
                rq_addr.push_back(pw_a);
            end
        endcase
        rq_mdata.push_back(m);
        cnt_m[src]++;
    endtask

    task automatic send_rsp(input logic [MW-1:0] m);
        logic [2:0] vb;
        int         src;
        rsp_v = 1'b1;
        rsp_m = m;
        rsp_d = {16{$urandom()}};
        src   = m[0] ? 2 : 1;
        if (!m[15]) vb = 3'b001;
        else if (cnt_m[src] > 0) begin
            vb = (src == 1) ? 3'b010 : 3'b100;
            cnt_m[src]--;
        end else vb = 3'b000;
        rs_vbits.push_back(vb);
        rs_mdata.push_back(m);
        rs_data.push_back(rsp_d);
    endtask

    task automatic test_reset();
        afu_v = 1'b1; vtp_v = 1'b1; pw_v = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({pw_rdy, vtp_rdy, afu_rdy, fiu_v, o_pw_rv, o_vtp_rv, o_afu_rv} !== 7'b0) begin
            failures++;
            $display("FAIL reset_valids: got rdy=%b fiu_v=%b rsp=%b, want all 0",
                     {pw_rdy, vtp_rdy, afu_rdy}, fiu_v, {o_pw_rv, o_vtp_rv, o_afu_rv});
        end
        checks++;
        if ({drain_done, err_tag, err_orph} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: got done/tag/orph=%b, want 000", {drain_done, err_tag, err_orph});
        end
        idle_inputs();
        #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 11; i++) begin
            next_cycle();
            vtp_v = 1'b1;
            vtp_a = 42'h100 + 42'(i < 8 ? i : 8);
            #1;
            checks++;
            if ({pw_rdy, vtp_rdy, afu_rdy} !== (i < 8 ? 3'b010 : 3'b000)) begin
                failures++;
                $display("FAIL b2b_ready[%0d]: got %b, want %b", i, {pw_rdy, vtp_rdy, afu_rdy},
                         (i < 8 ? 3'b010 : 3'b000));
            end
            if (i < 8) push_req(1);
        end
        next_cycle();
        send_rsp(16'h8000);
        #1;
        checks++;
        if (vtp_rdy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_full_on_rsp: got vtp_ready=%b, want 0", vtp_rdy);
        end
        next_cycle();
        #1;
        checks++;
        if ({pw_rdy, vtp_rdy, afu_rdy} !== 3'b010) begin
            failures++;
            $display("FAIL b2b_ninth: got %b, want 010", {pw_rdy, vtp_rdy, afu_rdy});
        end
        push_req(1);
        next_cycle();
        vtp_v = 1'b0;
    endtask

    task automatic test_contention();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            afu_v = 1'b1; vtp_v = 1'b1; pw_v = 1'b1;
            afu_m = 16'h1234;
            afu_a = 42'hA00 + 42'(i);
            vtp_a = 42'hB00 + 42'(i);
            pw_a  = 42'hC00 + 42'(i);
            #1;
            checks++;
            if ({pw_rdy, vtp_rdy, afu_rdy} !== (3'b001 << (i % 3))) begin
                failures++;
                $display("FAIL contention[%0d]: got %b, want %b", i, {pw_rdy, vtp_rdy, afu_rdy},
                         3'b001 << (i % 3));
            end
            push_req(i % 3);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            af = 1'b1;
            #1;
            checks++;
            if ({pw_rdy, vtp_rdy, afu_rdy} !== 3'b000) begin
                failures++;
                $display("FAIL backpressure[%0d]: got %b, want 000", i, {pw_rdy, vtp_rdy, afu_rdy});
            end
        end
        next_cycle();
        af = 1'b0;
        afu_a = 42'hA80;
        #1;
        checks++;
        if ({pw_rdy, vtp_rdy, afu_rdy} !== 3'b001) begin
            failures++;
            $display("FAIL bp_release: got %b, want 001", {pw_rdy, vtp_rdy, afu_rdy});
        end
        push_req(0);
        next_cycle();
        afu_v = 1'b0; vtp_v = 1'b0; pw_v = 1'b0;
    endtask

    task automatic test_rsp_steer();
        logic [MW-1:0] seq [5];
        seq[0] = 16'h0042; seq[1] = 16'h8000; seq[2] = 16'h8001;
        seq[3] = 16'h8000; seq[4] = 16'h8001;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            send_rsp(seq[i]);
        end
        repeat (2) next_cycle();
    endtask

    task automatic test_drain();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            pw_v = 1'b1;
            pw_a = 42'hD00 + 42'(i);
            #1;
            checks++;
            if ({pw_rdy, vtp_rdy, afu_rdy} !== 3'b100) begin
                failures++;
                $display("FAIL drain_fill[%0d]: got %b, want 100", i, {pw_rdy, vtp_rdy, afu_rdy});
            end
            push_req(2);
        end
        next_cycle();
        pw_v  = 1'b0;
        drain = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            afu_v = 1'b1; vtp_v = 1'b1; pw_v = 1'b1;
            afu_m = 16'h0011;
            afu_a = 42'hE10 + 42'(i);
            #1;
            checks++;
            if ({pw_rdy, vtp_rdy, afu_rdy, drain_done} !== 4'b0010) begin
                failures++;
                $display("FAIL drain_block[%0d]: got rdy=%b done=%b, want 001 0", i,
                         {pw_rdy, vtp_rdy, afu_rdy}, drain_done);
            end
            push_req(0);
        end
        next_cycle();
        afu_v = 1'b0; vtp_v = 1'b0; pw_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            send_rsp(16'h8001);
            #1;
            checks++;
            if (drain_done !== 1'b0) begin
                failures++;
                $display("FAIL drain_early[%0d]: got drain_done=%b, want 0", i, drain_done);
            end
        end
        next_cycle();
        vtp_v = 1'b1;
        vtp_a = 42'hF00;
        #1;
        checks++;
        if ({drain_done, pw_rdy, vtp_rdy, afu_rdy} !== 4'b1000) begin
            failures++;
            $display("FAIL drain_done: got done=%b rdy=%b, want 1 000", drain_done,
                     {pw_rdy, vtp_rdy, afu_rdy});
        end
        drain = 1'b0;
        next_cycle();
        #1;
        checks++;
        if ({drain_done, pw_rdy, vtp_rdy, afu_rdy} !== 4'b0010) begin
            failures++;
            $display("FAIL drain_resume: got done=%b rdy=%b, want 0 010", drain_done,
                     {pw_rdy, vtp_rdy, afu_rdy});
        end
        push_req(1);
        next_cycle();
        vtp_v = 1'b0;
    endtask

    task automatic test_errors();
        do_reset();
        next_cycle();
        afu_v = 1'b1;
        afu_a = 42'hE00;
        afu_m = 16'h8005;
        #1;
        checks++;
        if (afu_rdy !== 1'b1 || err_tag !== 1'b0) begin
            failures++;
            $display("FAIL err_tag_pre: got ready=%b err=%b, want 1 0", afu_rdy, err_tag);
        end
        push_req(0);
        next_cycle();
        afu_v = 1'b0;
        #1;
        checks++;
        if (err_tag !== 1'b1 || err_orph !== 1'b0) begin
            failures++;
            $display("FAIL err_tag_set: got tag=%b orph=%b, want 1 0", err_tag, err_orph);
        end
        send_rsp(16'h8001);
        next_cycle();
        #1;
        checks++;
        if (err_orph !== 1'b1 || err_tag !== 1'b1) begin
            failures++;
            $display("FAIL err_orphan: got orph=%b tag=%b, want 1 1", err_orph, err_tag);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            afu_v = 1'b1; vtp_v = 1'b1;
            afu_m = 16'h8000;
            afu_a = 42'h300 + 42'(i);
            vtp_a = 42'h400 + 42'(i);
            #1;
            checks++;
            if ({pw_rdy, vtp_rdy, afu_rdy} !== ((i % 2 == 0) ? 3'b001 : 3'b010)) begin
                failures++;
                $display("FAIL burst[%0d]: got %b, want %b", i, {pw_rdy, vtp_rdy, afu_rdy},
                         ((i % 2 == 0) ? 3'b001 : 3'b010));
            end
            push_req(i % 2);
        end
        #1;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({fiu_v, err_tag, drain_done, pw_rdy, vtp_rdy, afu_rdy} !== 6'b0) begin
            failures++;
            $display("FAIL mid_reset: got fiu_v=%b tag=%b done=%b rdy=%b, want all 0",
                     fiu_v, err_tag, drain_done, {pw_rdy, vtp_rdy, afu_rdy});
        end
        clear_model();
        idle_inputs();
        repeat (2) next_cycle();
        reset_n = 1'b1;
        mon_en  = 1'b1;
        next_cycle();
        send_rsp(16'h8000);
        next_cycle();
        #1;
        checks++;
        if (err_orph !== 1'b1) begin
            failures++;
            $display("FAIL cnt_cleared: got err_orphan=%b, want 1", err_orph);
        end
        next_cycle();
    endtask

    initial begin
        clear_model();
        test_reset();
        test_back_to_back();
        test_contention();
        test_backpressure();
        test_rsp_steer();
        test_drain();
        test_errors();
        test_reset_mid_burst();
        repeat (3) next_cycle();
        checks++;
        if (rq_addr.size() != 0 || rs_vbits.size() != 0) begin
            failures++;
            $display("FAIL leftover: got req=%0d rsp=%0d pending, want 0 0", rq_addr.size(),
                     rs_vbits.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cci_mpf_shim_tag_arb.md
Name: cci_mpf_shim_tag_arb

Overview:
Shares the FIU c0 read-request channel among three sources:
- AFU pass-through read traffic.
- Two internal MPF shim requesters: VTP page-table walker and PWRITE partial-write reader.

Internal requests are marked in mdata with the reserved shim bit plus a 1-bit shim tag (VTP=0, PWRITE=1). Read responses are steered back to their owner by decoding that tag. The block tracks outstanding internal reads per source and supports a drain handshake for shim reconfiguration.

Parameters:
ADDR_WIDTH, 42, cache-line address width
MDATA_WIDTH, 16, request/response mdata width
DATA_WIDTH, 512, response data width
RESERVED_IDX, 15, mdata bit reserved for shim-generated traffic (must be < MDATA_WIDTH and > 0)
MAX_OUTSTANDING, 8, per-internal-source outstanding read limit (power of 2, ≥2)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
afu_req_valid  in  1  AFU read request
afu_req_addr  in  ADDR_WIDTH  AFU address
afu_req_mdata  in  MDATA_WIDTH  AFU mdata
afu_req_ready  out  1  AFU request accepted this cycle
vtp_req_valid  in  1  VTP read request
vtp_req_addr  in  ADDR_WIDTH  VTP address
vtp_req_ready  out  1  VTP request accepted
pw_req_valid  in  1  PWRITE read request
pw_req_addr  in  ADDR_WIDTH  PWRITE address
pw_req_ready  out  1  PWRITE request accepted
fiu_req_valid  out  1  request to FIU c0
fiu_req_addr  out  ADDR_WIDTH  FIU address
fiu_req_mdata  out  MDATA_WIDTH  FIU mdata
fiu_almost_full  in  1  FIU c0 backpressure
fiu_rsp_valid  in  1  read response from FIU
fiu_rsp_mdata  in  MDATA_WIDTH  response mdata
fiu_rsp_data  in  DATA_WIDTH  response data
rsp_mdata  out  MDATA_WIDTH  registered response mdata (shared)
rsp_data  out  DATA_WIDTH  registered response data (shared)
afu_rsp_valid  out  1  response belongs to AFU
vtp_rsp_valid  out  1  response belongs to VTP
pw_rsp_valid  out  1  response belongs to PWRITE
drain_req  in  1  stop accepting internal requests
drain_done  out  1  drain complete, no internal reads outstanding
err_tag_collision  out  1  sticky: AFU mdata had the reserved bit set
err_orphan_rsp  out  1  sticky: tagged response with zero outstanding count

Behaviour:
- Reset (async on reset_n low): all valids, readies, drain_done and error flags are 0. Counters are 0. Round-robin pointer is AFU. FSM state is RUN.
- FSM states: RUN, DRAIN, DRAINED.
  - RUN→DRAIN when drain_req=1.
  - DRAIN→DRAINED when both counters are 0 (same cycle if they are already 0).
  - DRAINED→RUN when drain_req=0.
  - DRAIN→RUN if drain_req drops before the counters reach 0.
- drain_done = 1 only in DRAINED.
- Eligibility:
  - AFU is eligible whenever valid.
  - VTP/PWRITE are eligible only in RUN, when valid, and when their count < MAX_OUTSTANDING.
  - No grant at all while fiu_almost_full=1.
- Arbitration: round-robin over AFU→VTP→PWRITE. At most one grant per cycle. The pointer advances to the source after the granted one; it holds when there is no grant.
- Ready handshake: the *_req_ready signals are combinational; exactly the granted source sees ready=1. A request transfers when valid&ready.
- Request latency: 1 cycle. The granted request is registered onto fiu_req_* the next cycle; fiu_req_valid is high for exactly 1 cycle per transfer.
- mdata rules:
  - AFU mdata passes through, except bit RESERVED_IDX is forced 0.
  - If AFU mdata[RESERVED_IDX] was 1 at transfer, err_tag_collision sets and stays set until reset.
  - VTP mdata is all-zero except bit RESERVED_IDX=1 and bit0=0.
  - PWRITE mdata is all-zero except bit RESERVED_IDX=1 and bit0=1.
- Counters are $clog2(MAX_OUTSTANDING)+1 bits wide. A counter increments on its source's transfer and decrements on its source's response.
  - Increment and decrement in the same cycle: counter unchanged.
  - A counter never exceeds MAX_OUTSTANDING and never wraps.
- Response steering: registered, 1-cycle latency. rsp_mdata/rsp_data capture fiu_rsp_* every cycle fiu_rsp_valid=1.
  - mdata[RESERVED_IDX]=0 → afu_rsp_valid.
  - mdata[RESERVED_IDX]=1 and bit0=0 → vtp_rsp_valid.
  - mdata[RESERVED_IDX]=1 and bit0=1 → pw_rsp_valid.
  - At most one rsp_valid is high per cycle.
- Orphan response: a tagged response whose source count is 0 is dropped (no rsp_valid). err_orphan_rsp sets (sticky) and the counter stays 0.
- AFU responses are never counted or checked.
- Reset mid-operation: all state clears immediately. Responses to requests issued before reset are the responsibility of the system reset sequence.

Test Plan:
- Back-to-back single source: VTP requests addr 0x100..0x107 valid continuously → 8 transfers with mdata=0x8000. The 9th request is held (vtp_req_ready=0) until one response with mdata 0x8000 arrives; it then transfers the cycle after that response.
- Three-way contention: all three valid for 6 cycles with fiu_almost_full=0 → grant order AFU, VTP, PW, AFU, VTP, PW. PW mdata=0x8001. AFU mdata 0x1234 passes unchanged.
- Backpressure: fiu_almost_full=1 for 5 cycles with all valid → no readies, no fiu_req_valid. Deassert → AFU granted first if the pointer was at AFU.
- Response steering: inject mdata 0x0042, then 0x8000, then 0x8001, each with VTP/PW count ≥1 → afu_rsp_valid, vtp_rsp_valid, pw_rsp_valid, each one cycle after input, with data echoed. Counters decrement.
- Drain: 3 PW reads outstanding, assert drain_req → PW/VTP ready held 0 while AFU is still granted. drain_done rises 1 cycle after the third PW response. Drop drain_req → RUN, internal requests accepted again.
- Errors and reset: AFU mdata 0x8005 → fiu_req_mdata 0x0005 and err_tag_collision=1. A response with mdata 0x8001 while the PW count is 0 → no pw_rsp_valid and err_orphan_rsp=1. Pulse reset_n low mid-burst → outputs 0 immediately and counters cleared.
